// File: rtl/draw_pixel_writer_pkg.sv
// Shared defaults, address-width helper and FSM encoding for the draw pixel writer.
package draw_pkg;

    localparam int FB_W_DEF       = 160;
    localparam int FB_H_DEF       = 120;
    localparam int FIFO_DEPTH_DEF = 4;

    // Bits needed to address n pixels; never 0 so a 1x1 framebuffer still gets a bus.
    function automatic int addr_bits(input int n);
        int b;
        b = 1;
        while ((1 << b) < n) b++;
        return b;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_FLUSH,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/draw_pixel_writer_if.sv
// Framebuffer write port shared between the pixel writer (master) and the framebuffer arbiter (slave).
interface draw_pixel_writer_if #(
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 8
) ();

    logic               FB_WE;
    logic               FB_READY;
    logic [ADDR_W-1:0]  FB_ADDR;
    logic [COLOR_W-1:0] FB_DATA;

    modport master (output FB_WE, FB_ADDR, FB_DATA, input FB_READY);
    modport slave  (input FB_WE, FB_ADDR, FB_DATA, output FB_READY);

endinterface

// File: rtl/draw_pixel_writer_fifo.sv
// Small synchronous FIFO with combinational head read (first-word fall-through) and full/empty flags.
module draw_pixel_fifo #(
    parameter int DW    = 23,
    parameter int DEPTH = 4
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign rdata = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/draw_pixel_writer.sv
// Pixel writer: dedups/clips draw-unit coordinates, queues them and writes the framebuffer; also clears it.
// Optional macro DRAW_PIXEL_COUNT_EN enables the saturating PIX_COUNT counter of drawn-pixel writes.
module draw_pixel_writer
    import draw_pkg::*;
#(
    parameter int FB_W       = FB_W_DEF,
    parameter int FB_H       = FB_H_DEF,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                ENB,
    input  logic [7:0]          X_IN,
    input  logic [7:0]          Y_IN,
    input  logic                FINISH_IN,
    input  logic [COLOR_W-1:0]  COLOR,
    input  logic                CLEAR,
    input  logic [COLOR_W-1:0]  CLEAR_COLOR,
    draw_pixel_writer_if.master fb,
    output logic                BUSY,
    output logic                DONE,
    output logic                OVERFLOW,
    output logic [15:0]         PIX_COUNT
);

    localparam int                ADDR_W    = addr_bits(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pix_t;

    state_t             state, state_nxt;
    logic               fin_q;
    logic               last_vld;
    logic [7:0]         last_x, last_y;
    logic               adr_vld;
    pix_t               adr_pix;
    logic               wr_vld;
    pix_t               wr_pix;
    pix_t               fifo_pix;
    logic               fifo_full, fifo_empty;
    logic [ADDR_W-1:0]  clr_addr;
    logic [COLOR_W-1:0] clr_color;
    logic               overflow_q;

    logic accept, in_fb, draw_entry, clr_entry;
    logic pix_fire, clr_fire, wr_load, fifo_pop, bypass, fifo_push, lost;

    assign draw_entry = (state == ST_IDLE) && !CLEAR && ENB;
    assign clr_entry  = (state == ST_IDLE) && CLEAR;
    assign accept     = (state == ST_DRAW) && ENB &&
                        (!last_vld || X_IN != last_x || Y_IN != last_y);
    assign in_fb      = ({1'b0, X_IN} < 9'(FB_W)) && ({1'b0, Y_IN} < 9'(FB_H));

    // Output register refills from the FIFO head, or straight from the address stage when the FIFO is empty.
    assign pix_fire  = wr_vld && fb.FB_READY;
    assign clr_fire  = (state == ST_CLEAR) && fb.FB_READY;
    assign wr_load   = !wr_vld || pix_fire;
    assign fifo_pop  = wr_load && !fifo_empty;
    assign bypass    = adr_vld && wr_load && fifo_empty;
    assign fifo_push = adr_vld && !bypass && (!fifo_full || fifo_pop);
    assign lost      = adr_vld && !bypass && fifo_full && !fifo_pop;

    draw_pixel_fifo #(
        .DW    ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .push   (fifo_push),
        .wdata  (adr_pix),
        .pop    (fifo_pop),
        .rdata  (fifo_pix),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        DONE      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (CLEAR)    state_nxt = ST_CLEAR;
                else if (ENB) state_nxt = ST_DRAW;
            end
            ST_DRAW: begin
                if ((FINISH_IN && !fin_q) || !ENB) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!adr_vld && fifo_empty && !wr_vld) begin
                    state_nxt = ST_IDLE;
                    DONE      = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_fire && clr_addr == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                    DONE      = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state    <= ST_IDLE;
            fin_q    <= 1'b0;
            last_vld <= 1'b0;
            last_x   <= '0;
            last_y   <= '0;
        end else begin
            state <= state_nxt;
            fin_q <= FINISH_IN;
            if (draw_entry) begin
                last_vld <= 1'b0;
            end else if (accept) begin
                last_vld <= 1'b1;
                last_x   <= X_IN;
                last_y   <= Y_IN;
            end
        end
    end

    // Clipped samples still update the last coordinate above but never enter the address stage.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            adr_vld <= 1'b0;
            adr_pix <= '0;
            wr_vld  <= 1'b0;
            wr_pix  <= '0;
        end else begin
            adr_vld <= accept && in_fb;
            if (accept && in_fb) begin
                adr_pix.addr  <= ADDR_W'(Y_IN) * ADDR_W'(FB_W) + ADDR_W'(X_IN);
                adr_pix.color <= COLOR;
            end
            if (wr_load) begin
                wr_vld <= fifo_pop || bypass;
                if (fifo_pop)    wr_pix <= fifo_pix;
                else if (bypass) wr_pix <= adr_pix;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            clr_addr   <= '0;
            clr_color  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (clr_entry) begin
                clr_addr  <= '0;
                clr_color <= CLEAR_COLOR;
            end else if (clr_fire) begin
                clr_addr  <= clr_addr + 1'b1;
            end
            if (clr_entry) overflow_q <= 1'b0;
            else if (lost) overflow_q <= 1'b1;
        end
    end

`ifdef DRAW_PIXEL_COUNT_EN
    logic [15:0] pix_cnt;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                                pix_cnt <= '0;
        else if (draw_entry)                       pix_cnt <= '0;
        else if (pix_fire && pix_cnt != 16'hFFFF)  pix_cnt <= pix_cnt + 16'd1;
    end

    assign PIX_COUNT = pix_cnt;
`else
    assign PIX_COUNT = '0;
`endif

    assign fb.FB_WE   = wr_vld || (state == ST_CLEAR);
    assign fb.FB_ADDR = (state == ST_CLEAR) ? clr_addr  : wr_pix.addr;
    assign fb.FB_DATA = (state == ST_CLEAR) ? clr_color : wr_pix.color;
    assign BUSY       = (state != ST_IDLE);
    assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_draw_pixel_writer.sv
// Bench for draw_pixel_writer: constant vector table, directed corner sequences and random draws vs a list model.
module tb_draw_pixel_writer;

    localparam int FB_W = 160;
    localparam int FB_H = 120;
    localparam int CW   = 8;
    localparam int AW   = 15;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          ENB = 1'b0;
    logic          FINISH_IN = 1'b0;
    logic          CLEAR = 1'b0;
    logic [7:0]    X_IN = '0;
    logic [7:0]    Y_IN = '0;
    logic [CW-1:0] COLOR = '0;
    logic [CW-1:0] CLEAR_COLOR = '0;
    logic          BUSY, DONE, OVERFLOW;
    logic [15:0]   PIX_COUNT;

    draw_pixel_writer_if #(.ADDR_W(AW), .COLOR_W(CW)) fb ();

    draw_pixel_writer #(
        .FB_W       (FB_W),
        .FB_H       (FB_H),
        .COLOR_W    (CW),
        .FIFO_DEPTH (4)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .ENB         (ENB),
        .X_IN        (X_IN),
        .Y_IN        (Y_IN),
        .FINISH_IN   (FINISH_IN),
        .COLOR       (COLOR),
        .CLEAR       (CLEAR),
        .CLEAR_COLOR (CLEAR_COLOR),
        .fb          (fb),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .OVERFLOW    (OVERFLOW),
        .PIX_COUNT   (PIX_COUNT)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int c;
        bit we;
        int addr;
    } vec_t;

    wr_t  wq[$];
    wr_t  eq[$];
    int   sx[$], sy[$], sc[$];
    vec_t tbl[10];
    int   cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
    int   n_chk = 0, n_pass = 0;
    bit   rnd_rdy = 0, tog_rdy = 0;

    // Writes complete at the next rising edge; observe them mid-cycle.
    always @(negedge ACLK) begin
        cyc++;
        if (!ARESET) begin
            if (fb.FB_WE && fb.FB_READY) begin
                wq.push_back('{addr: fb.FB_ADDR, data: fb.FB_DATA});
                last_wr_cyc = cyc;
            end
            if (DONE) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
        if (tog_rdy) begin
            fb.FB_READY = ~fb.FB_READY;
        end else if (rnd_rdy) begin
            if (!fb.FB_READY) fb.FB_READY = 1'b1;
            else              fb.FB_READY = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            step();
            n++;
        end
        step();
        step();
        chk({tag, "_done"}, 32'(done_cnt), 1);
        chk({tag, "_busy"}, 32'(BUSY), 0);
    endtask

    // Reference: each accepted sample is new vs the previous accepted one; in-bounds ones write Y*W+X.
    task automatic build_exp();
        bit lv;
        int lx, ly;
        lv = 0; lx = 0; ly = 0;
        eq.delete();
        foreach (sx[i]) begin
            if (!lv || sx[i] != lx || sy[i] != ly) begin
                lv = 1; lx = sx[i]; ly = sy[i];
                if (sx[i] < FB_W && sy[i] < FB_H)
                    eq.push_back('{addr: AW'(sy[i] * FB_W + sx[i]), data: CW'(sc[i])});
            end
        end
    endtask

    task automatic cmp_writes(input string tag);
        int bad;
        bad = -1;
        n_chk++;
        if (wq.size() != eq.size()) begin
            $display("FAIL %s_writes: got %0d writes, expected %0d", tag, wq.size(), eq.size());
        end else begin
            foreach (eq[i]) if (bad < 0 && wq[i] !== eq[i]) bad = i;
            if (bad < 0) n_pass++;
            else $display("FAIL %s_writes[%0d]: got addr %0d data %0h, expected addr %0d data %0h",
                          tag, bad, wq[bad].addr, wq[bad].data, eq[bad].addr, eq[bad].data);
        end
    endtask

    // The cycle in which ENB lifts the writer out of idle starts the draw and is not itself sampled.
    task automatic drive_session(input string tag);
        wq.delete();
        done_cnt = 0;
        ENB = 1'b1; X_IN = 8'(sx[0]); Y_IN = 8'(sy[0]); COLOR = CW'(sc[0]);
        step();
        foreach (sx[i]) begin
            X_IN = 8'(sx[i]); Y_IN = 8'(sy[i]); COLOR = CW'(sc[i]);
            step();
        end
        ENB = 1'b0;
        wait_done(tag, 2000);
    endtask

    task automatic run_session(input string tag);
        drive_session(tag);
        build_exp();
        cmp_writes(tag);
        chk({tag, "_ovf"}, 32'(OVERFLOW), 0);
`ifdef DRAW_PIXEL_COUNT_EN
        chk({tag, "_pix"}, 32'(PIX_COUNT), eq.size());
`else
        chk({tag, "_pix"}, 32'(PIX_COUNT), 0);
`endif
    endtask

    initial begin
        int n, bad, x, y, h;
        tbl[0] = '{2,   3,   'h11, 1, 482};
        tbl[1] = '{3,   3,   'h22, 1, 483};
        tbl[2] = '{200, 5,   'h33, 0, 0};
        tbl[3] = '{159, 119, 'h44, 1, 19199};
        tbl[4] = '{0,   0,   'h55, 1, 0};
        tbl[5] = '{160, 0,   'h66, 0, 0};
        tbl[6] = '{0,   120, 'h77, 0, 0};
        tbl[7] = '{159, 0,   'h88, 1, 159};
        tbl[8] = '{0,   119, 'h99, 1, 19040};
        tbl[9] = '{255, 255, 'hAA, 0, 0};
        fb.FB_READY = 1'b1;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_we",   32'(fb.FB_WE),   0);
        chk("rst_addr", 32'(fb.FB_ADDR), 0);
        chk("rst_data", 32'(fb.FB_DATA), 0);
        chk("rst_busy", 32'(BUSY),       0);
        chk("rst_done", 32'(DONE),       0);
        chk("rst_ovf",  32'(OVERFLOW),   0);
        chk("rst_pix",  32'(PIX_COUNT),  0);
        ARESET = 1'b0;
        step();

        // Single-pixel draws against constant expectations.
        for (int i = 0; i < 10; i++) begin
            sx = {tbl[i].x}; sy = {tbl[i].y}; sc = {tbl[i].c};
            drive_session($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_nwr", i), 32'(wq.size()), tbl[i].we ? 1 : 0);
            if (tbl[i].we && wq.size() == 1) begin
                chk($sformatf("vec%0d_addr", i), 32'(wq[0].addr), tbl[i].addr);
                chk($sformatf("vec%0d_data", i), 32'(wq[0].data), tbl[i].c);
            end
            chk($sformatf("vec%0d_ovf", i), 32'(OVERFLOW), 0);
        end

        // Held coordinate then a neighbour; FINISH_IN ends the draw.
        wq.delete(); done_cnt = 0;
        COLOR = 8'h1F; ENB = 1'b1; X_IN = 8'd2; Y_IN = 8'd3;
        step();
        repeat (3) step();
        X_IN = 8'd3;
        step();
        FINISH_IN = 1'b1;
        step();
        ENB = 1'b0;
        wait_done("line", 200);
        FINISH_IN = 1'b0;
        sx = {2, 2, 2, 3}; sy = {3, 3, 3, 3}; sc = {'h1F, 'h1F, 'h1F, 'h1F};
        build_exp();
        cmp_writes("line");
        chk("line_done_lat", 32'(done_cyc - last_wr_cyc), 1);

        // Random draws with a stalling port that never stalls two cycles running.
        rnd_rdy = 1;
        for (int s = 0; s < 15; s++) begin
            sx.delete(); sy.delete(); sc.delete();
            repeat ($urandom_range(5, 25)) begin
                x = $urandom_range(150, 170);
                y = $urandom_range(110, 125);
                h = $urandom_range(2, 3);
                repeat (h) begin
                    sx.push_back(x); sy.push_back(y); sc.push_back($urandom_range(0, 255));
                end
            end
            run_session($sformatf("rnd%0d", s));
        end
        rnd_rdy = 0;
        fb.FB_READY = 1'b1;

        sx.delete(); sy.delete(); sc.delete();
        for (int i = 0; i < 10; i++) begin
            sx.push_back(i); sy.push_back(50); sc.push_back(i + 1);
        end
        run_session("line10");

        // Port stalled while six distinct pixels arrive: five fit, the sixth is lost.
        fb.FB_READY = 1'b0;
        sx = {10, 11, 12, 13, 14, 15}; sy = {10, 10, 10, 10, 10, 10}; sc = {1, 2, 3, 4, 5, 6};
        wq.delete(); done_cnt = 0;
        ENB = 1'b1; X_IN = 8'd10; Y_IN = 8'd10; COLOR = 8'd1;
        step();
        foreach (sx[i]) begin
            X_IN = 8'(sx[i]); Y_IN = 8'(sy[i]); COLOR = CW'(sc[i]);
            step();
        end
        ENB = 1'b0;
        repeat (5) step();
        chk("ovf_flag",  32'(OVERFLOW),   1);
        chk("ovf_we",    32'(fb.FB_WE),   1);
        chk("ovf_hold",  32'(fb.FB_ADDR), 1610);
        chk("ovf_nowr",  32'(wq.size()),  0);
        fb.FB_READY = 1'b1;
        wait_done("ovf", 200);
        build_exp();
        void'(eq.pop_back());
        cmp_writes("ovf");

        // Full clear with the port toggling.
        wq.delete(); done_cnt = 0;
        CLEAR_COLOR = 8'h00; tog_rdy = 1; CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        chk("clr_busy", 32'(BUSY),     1);
        chk("clr_ovf",  32'(OVERFLOW), 0);
        wait_done("clr", 50000);
        tog_rdy = 0;
        fb.FB_READY = 1'b1;
        chk("clr_count", 32'(wq.size()), FB_W * FB_H);
        bad = -1;
        foreach (wq[i]) if (bad < 0 && (wq[i].addr != AW'(i) || wq[i].data != 8'h00)) bad = i;
        chk("clr_seq_first_bad", 32'(bad), 32'hFFFF_FFFF);

        // Reset mid-clear while ENB presents a coordinate that must not be queued.
        wq.delete(); done_cnt = 0;
        CLEAR_COLOR = 8'hA5; COLOR = 8'h3C; CLEAR = 1'b1;
        step();
        CLEAR = 1'b0; ENB = 1'b1; X_IN = 8'd5; Y_IN = 8'd5;
        n = 0;
        while (!(fb.FB_WE && fb.FB_ADDR == 500) && n < 2000) begin
            @(negedge ACLK);
            n++;
        end
        chk("ar_addr", 32'(fb.FB_ADDR), 500);
        chk("ar_data", 32'(fb.FB_DATA), 'hA5);
        #1 ARESET = 1'b1;
        #1;
        chk("ar_we",   32'(fb.FB_WE), 0);
        chk("ar_busy", 32'(BUSY),     0);
        chk("ar_done", 32'(DONE),     0);
        bad = -1;
        foreach (wq[i]) if (bad < 0 && (wq[i].addr != AW'(i) || wq[i].data != 8'hA5)) bad = i;
        chk("ar_clr_seq_first_bad", 32'(bad), 32'hFFFF_FFFF);
        chk("ar_clr_min", 32'(wq.size() >= 500), 1);
        ENB = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        step();
        chk("ar_idle", 32'(BUSY), 0);
        sx = {40, 40, 41, 200, 42}; sy = {7, 7, 7, 7, 7}; sc = {'h10, 'h20, 'h30, 'h40, 'h50};
        run_session("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/draw_pixel_writer.md
Name: draw_pixel_writer

Overview:
- Consumer end of the draw pipeline's pixel output. It takes the X/Y coordinate stream and FINISH level produced by the draw unit.
- Suppresses repeated coordinates and clips to framebuffer bounds. Converts each surviving pixel to a linear framebuffer address and writes COLOR through a shared framebuffer write port, which may stall.
- Also performs a full-screen clear sweep on request. A small FIFO absorbs write-port stalls, because the draw unit has no backpressure.

Parameters:
- FB_W, 160, framebuffer width in pixels (1..256).
- FB_H, 120, framebuffer height in pixels (1..256).
- COLOR_W, 8, pixel data width.
- FIFO_DEPTH, 4, pixel FIFO entries (power of 2, >=2).
- ADDR_W, derived: clog2(FB_W*FB_H). This is 15 for the defaults.

Ports:
- ACLK  in  1  system clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- ENB  in  1  drawing active; gates sampling of X_IN/Y_IN.
- X_IN  in  8  pixel X from the draw unit.
- Y_IN  in  8  pixel Y from the draw unit.
- FINISH_IN  in  1  draw-unit finish level.
- COLOR  in  COLOR_W  colour written for drawn pixels; sampled per pixel.
- CLEAR  in  1  one-cycle request to fill the whole framebuffer.
- CLEAR_COLOR  in  COLOR_W  fill value; sampled when CLEAR is accepted.
- FB_READY  in  1  framebuffer port grant; a write completes on a cycle where FB_WE && FB_READY.
- FB_WE  out  1  write request.
- FB_ADDR  out  ADDR_W  linear address, Y*FB_W+X.
- FB_DATA  out  COLOR_W  write data.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when a draw or clear completes.
- OVERFLOW  out  1  sticky; a pixel was lost because the FIFO was full. Cleared by ARESET or an accepted CLEAR.
- PIX_COUNT  out  16  pixels written; see Optional Feature.

Behaviour:
- Reset values: FB_WE=0, FB_ADDR=0, FB_DATA=0, BUSY=0, DONE=0, OVERFLOW=0, PIX_COUNT=0. State=IDLE, FIFO empty, last-coordinate-valid flag cleared.
- Asserting ARESET mid-draw or mid-clear aborts immediately. In-flight pixels are discarded.
- FSM states are IDLE, DRAW, FLUSH, CLEAR.
- IDLE -> CLEAR on CLEAR=1. CLEAR has priority if ENB rises in the same cycle.
- IDLE -> DRAW on ENB=1 with CLEAR=0.
- DRAW -> FLUSH on the rising edge of FINISH_IN, or on ENB falling.
- FLUSH -> IDLE when the FIFO is empty and no write is pending. DONE pulses on that transition.
- CLEAR -> IDLE after the write to address FB_W*FB_H-1 completes. DONE pulses on that transition.
- CLEAR sweep:
  - Addresses run 0..FB_W*FB_H-1 ascending with FB_DATA=CLEAR_COLOR. Each address advances only on FB_WE&&FB_READY.
  - CLEAR received while in DRAW/FLUSH/CLEAR is ignored.
  - ENB is ignored during CLEAR; coordinates arriving then are not queued.
- Pixel capture (in DRAW, when ENB=1), once per cycle:
  - A sample is accepted if the last-valid flag is clear, or if (X_IN,Y_IN) differs from the last accepted coordinate.
  - The last-valid flag clears on entry to DRAW, so the first coordinate is always accepted.
  - An accepted sample with X_IN>=FB_W or Y_IN>=FB_H is dropped. It is not an overflow, and it still updates the last coordinate.
  - A surviving pixel's address is computed in a registered stage (capture->address: 1 cycle) and then pushed with COLOR.
  - Push while the FIFO is full: the pixel is dropped and OVERFLOW is set.
  - A simultaneous push and pop when full is legal; the pop frees the slot and the push succeeds.
- Write side:
  - FB_WE=1 whenever the FIFO output register holds a valid entry. FB_ADDR/FB_DATA stay stable until FB_READY.
  - Best-case latency from sample to FB_WE is 2 cycles; FIFO empty is first-word fall-through into the output register.
  - Throughput is 1 pixel/cycle while FB_READY=1.
- Arithmetic: Y*FB_W+X is computed at ADDR_W bits. Clipping guarantees no overflow.

Optional Feature:
- Macro: DRAW_PIXEL_COUNT_EN.
- Defined: PIX_COUNT increments on every completed drawn-pixel write (not clear writes), saturates at 16'hFFFF, and resets to 0 on entry to DRAW.
- Undefined: PIX_COUNT is tied to 0 and no counter is synthesised.

Decomposition:
- Package draw_pkg holds FB_W/FB_H defaults, the ADDR_W clog2 function, and the state enum {IDLE, DRAW, FLUSH, CLEAR}.
- One sub-module, draw_pixel_fifo: a synchronous FWFT FIFO of {addr, color}, with full/empty flags.

Test Plan:
- Line (2,3) held 3 cycles, then (3,3), with FB_READY=1 and COLOR=8'h1F -> exactly two writes: addr 482 and 483, data 1F. Then FINISH_IN rises -> DONE one cycle after the last write.
- Coordinate (200,5) with FB_W=160 -> no write, OVERFLOW=0. Coordinate (159,119) -> write to addr 19199.
- FB_READY=0 while 6 distinct pixels arrive (FIFO_DEPTH=4) -> OVERFLOW=1. Once FB_READY rises, 4 queued pixels are written in order (plus the output register), and the 6th is lost.
- CLEAR with CLEAR_COLOR=8'h00 and FB_READY toggling 1/0 -> 19200 writes, addresses 0..19199 ascending, no gaps. DONE pulses once and BUSY drops.
- ARESET asserted mid-CLEAR at addr 500 -> FB_WE=0 immediately, BUSY=0, state IDLE. A subsequent draw works normally.
- With DRAW_PIXEL_COUNT_EN defined, a 10-pixel line -> PIX_COUNT=10. With the macro undefined -> PIX_COUNT stays 0.
